// File: rtl/secded_pkg.sv
// Shared SECDED definitions: check-width derivation, Hamming positions, write-path encoder.
package secded_pkg;

    typedef enum logic [1:0] {CLEAN, CE_DATA, CE_CHK, UE} err_class_e;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_CHK_W  = 8;

    // r+1, where r is the smallest value with 2^r >= data_w + r + 1
    function automatic int chk_w(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) r++;
        return r + 1;
    endfunction

    // j-th integer >= 3 that is not a power of two
    function automatic int hpos(input int j);
        int k;
        int res;
        k   = 0;
        res = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k == j && res == 0) res = p;
                k++;
            end
        end
        return res;
    endfunction

    // Check bits for the low data_w bits of data; bits above chk_w(data_w)-1 are zero.
    // The Hamming check vector is the XOR of the positions of all set data bits.
    function automatic logic [MAX_CHK_W-1:0] encode(input logic [MAX_DATA_W-1:0] data,
                                                    input int data_w);
        logic [MAX_CHK_W-1:0] chk;
        logic                 par;
        int                   cw;
        int                   hp;
        chk = '0;
        par = 1'b0;
        cw  = chk_w(data_w);
        for (int j = 0; j < MAX_DATA_W; j++) begin
            if (j < data_w && data[6'(j)]) begin
                hp  = hpos(j);
                chk = chk ^ MAX_CHK_W'(hp);
                par = ~par;
            end
        end
        chk[3'(cw - 1)] = par ^ (^chk);
        return chk;
    endfunction

endpackage

// File: rtl/secded_sat_cnt.sv
// Saturating event counter; a clear coinciding with an increment leaves the count at 1.
module secded_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control, error counters and first-error log.
// Optional ECC_ERR_INJECT_EN adds inj_mask, XORed into accepted codewords ahead of stage 1.
module secded_dec_pipe
    import secded_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  TAG_W   = 16,
    parameter int  COUNT_W = 16,
    localparam int CHK_W   = chk_w(DATA_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W+CHK_W-1:0] in_code,
`ifdef ECC_ERR_INJECT_EN
    input  logic [DATA_W+CHK_W-1:0] inj_mask,
`endif
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_ce,
    output logic                    out_ue,
    output logic [COUNT_W-1:0]      ce_cnt,
    output logic [COUNT_W-1:0]      ue_cnt,
    output logic                    log_valid,
    output logic [CHK_W-1:0]        log_syn,
    output logic [TAG_W-1:0]        log_tag,
    input  logic                    stat_clr
);

    localparam int SYN_W    = CHK_W - 1;
    localparam int CODE_W   = DATA_W + CHK_W;
    localparam int HPOS_MAX = hpos(DATA_W - 1);

    logic [CODE_W-1:0] code_c;
    logic [SYN_W-1:0]  syn_c;
    logic              par_c;
    logic [DATA_W-1:0] col_mask [SYN_W];
    logic [DATA_W-1:0] hit;

    logic              vld_p1;
    logic [SYN_W-1:0]  syn_p1;
    logic              par_p1;
    logic [DATA_W-1:0] data_p1;
    logic [TAG_W-1:0]  tag_p1;

    logic              vld_p2;
    logic [CHK_W-1:0]  syn_p2;

    logic              s1_adv;
    logic              s2_adv;
    err_class_e        cls_c;
    logic [DATA_W-1:0] fix_c;
    logic              out_hs;
    logic              ce_ev;
    logic              ue_ev;
    logic              err_ev;

`ifdef ECC_ERR_INJECT_EN
    assign code_c = in_code ^ inj_mask;
`else
    assign code_c = in_code;
`endif

    // Per data bit: its Hamming position drives both the syndrome columns and the correction match.
    for (genvar j = 0; j < DATA_W; j++) begin : g_pos
        localparam int HP = hpos(j);
        assign hit[j] = (syn_p1 == SYN_W'(HP));
        for (genvar i = 0; i < SYN_W; i++) begin : g_bit
            assign col_mask[i][j] = HP[i];
        end
    end

    for (genvar i = 0; i < SYN_W; i++) begin : g_syn
        assign syn_c[i] = code_c[DATA_W+i] ^ (^(code_c[DATA_W-1:0] & col_mask[i]));
    end
    assign par_c = ^code_c;

    assign s2_adv    = !vld_p2 || out_ready;
    assign s1_adv    = !vld_p1 || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_p2;

    // ---- stage 1: syndrome, overall parity, raw data, tag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            syn_p1  <= '0;
            par_p1  <= 1'b0;
            data_p1 <= '0;
            tag_p1  <= '0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                syn_p1  <= syn_c;
                par_p1  <= par_c;
                data_p1 <= code_c[DATA_W-1:0];
                tag_p1  <= in_tag;
            end
        end
    end

    always_comb begin
        cls_c = CLEAN;
        if (par_p1) begin
            if ((syn_p1 & (syn_p1 - SYN_W'(1))) == '0) begin
                cls_c = CE_CHK;
            end else if (syn_p1 > SYN_W'(HPOS_MAX)) begin
                cls_c = UE;
            end else begin
                cls_c = CE_DATA;
            end
        end else if (syn_p1 != '0) begin
            cls_c = UE;
        end
    end

    assign fix_c = (cls_c == CE_DATA) ? (data_p1 ^ hit) : data_p1;

    // ---- stage 2: classified and corrected result, held while stalled ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            out_ce   <= 1'b0;
            out_ue   <= 1'b0;
            syn_p2   <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            out_ce <= vld_p1 && (cls_c == CE_DATA || cls_c == CE_CHK);
            out_ue <= vld_p1 && (cls_c == UE);
            if (vld_p1) begin
                out_data <= fix_c;
                out_tag  <= tag_p1;
                syn_p2   <= {par_p1, syn_p1};
            end
        end
    end

    assign out_hs = vld_p2 && out_ready;
    assign ce_ev  = out_hs && out_ce;
    assign ue_ev  = out_hs && out_ue;
    assign err_ev = ce_ev || ue_ev;

    secded_sat_cnt #(.W(COUNT_W)) u_ce_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (ce_ev),
        .cnt   (ce_cnt)
    );

    secded_sat_cnt #(.W(COUNT_W)) u_ue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (ue_ev),
        .cnt   (ue_cnt)
    );

    // A clear re-arms the log, so an error in the same cycle becomes the new first error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid <= 1'b0;
            log_syn   <= '0;
            log_tag   <= '0;
        end else if (err_ev && (stat_clr || !log_valid)) begin
            log_valid <= 1'b1;
            log_syn   <= syn_p2;
            log_tag   <= out_tag;
        end else if (stat_clr) begin
            log_valid <= 1'b0;
            log_syn   <= '0;
            log_tag   <= '0;
        end
    end

endmodule

// File: doc/secded_dec_pipe.md
Name: secded_dec_pipe

Overview:
Parametrised, pipelined SECDED decoder; successor to the fixed 32-bit combinational codec. Adds valid/ready flow control, a 2-stage pipeline, saturating CE/UE counters and a sticky first-error log. Sits between cache data/tag SRAM read ports and the cache controller; the matching encoder stays combinational on the write path.

Parameters:
DATA_W, 32, data bits per codeword (8..64)
TAG_W, 16, sideband tag (e.g. set/way address) passed through with each word
COUNT_W, 16, width of each saturating error counter
CHK_W, derived localparam, r+1 where r is the smallest value with 2^r >= DATA_W+r+1 (32->7, 64->8); not overridable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  codeword offered
in_ready  out  1  decoder accepts
in_code  in  DATA_W+CHK_W  codeword: [DATA_W-1:0] data, [DATA_W+CHK_W-1:DATA_W] check
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_data  out  DATA_W  corrected data (raw data on UE)
out_tag  out  TAG_W  tag of out_data
out_ce  out  1  single error corrected (data or check bit)
out_ue  out  1  uncorrectable error
ce_cnt  out  COUNT_W  saturating CE count
ue_cnt  out  COUNT_W  saturating UE count
log_valid  out  1  sticky: log_syn/log_tag hold first error since clear
log_syn  out  CHK_W  {overall parity, syndrome} of logged error
log_tag  out  TAG_W  tag of logged error
stat_clr  in  1  one-cycle pulse: clear counters and log

Behaviour:
- Code: extended Hamming. Data bit j takes Hamming position p(j) = j-th integer >=3 that is not a power of two (bit0->3, bit1->5, bit2->6, bit3->7, bit4->9, bit5->10). Check bit i (i<CHK_W-1) = XOR of data bits whose p(j) has bit i set. Check bit CHK_W-1 = XOR of all other DATA_W+CHK_W-1 bits.
- Stage 1 registers the syndrome s (CHK_W-1 bits, recomputed XOR stored check), the overall parity P over the full codeword, the raw data and the tag.
- Stage 2 classifies and corrects:
  - s=0, P=0: clean.
  - P=1, s=0: overall-parity bit error -> CE, data unchanged.
  - P=1, s a power of two: check-bit error -> CE, data unchanged.
  - P=1, s=p(j) for some j<DATA_W: flip data bit j -> CE.
  - P=1, s beyond the highest assigned position: UE.
  - P=0, s!=0: double error -> UE, raw data out.
- Handshake: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. A transfer occurs on valid&&ready. Latency is 2 cycles from input accept to out_valid with no stall. Full throughput: 1 word/cycle. Capacity is 2 words.
- out_* stay stable while out_valid && !out_ready.
- Counters increment on output handshake with out_ce/out_ue set, and saturate at all-ones.
- Log captures {P,s} and tag on the first CE or UE output handshake while log_valid=0, then holds.
- stat_clr priority: a clear and an event in the same cycle leave the counter at 1 and the log capturing the new event.
- Reset (any cycle, including mid-stall): both stage valids=0, out_valid=0, out_ce=out_ue=0, out_data=0, out_tag=0, counters=0, log_valid=0, log_syn=0, log_tag=0. In-flight words are discarded. in_ready=1 after reset.

Optional Feature:
ECC_ERR_INJECT_EN: adds input port inj_mask (DATA_W+CHK_W). inj_mask is XORed into in_code before stage 1, on accepted words only. Without the macro the port is absent and the codeword passes unmodified. Used for silicon and bench fault injection.

Decomposition:
- Package secded_pkg holds the function chk_w(data_w), the function hpos(j) returning the Hamming position, the function encode(data) (shared with the write-path encoder and the bench model), and the typedef err_class_e {CLEAN, CE_DATA, CE_CHK, UE}.
- One natural sub-module: secded_sat_cnt (parametrised saturating counter with clear and increment), instantiated for CE and UE.

Test Plan:
- Clean word: DATA_W=32, encode(0xDEADBEEF), out_ready=1 -> out_data 0xDEADBEEF two cycles later, out_ce=out_ue=0, counters 0.
- Single data-bit error: encode(0xDEADBEEF) with bit5 flipped -> out_data 0xDEADBEEF, out_ce=1, ce_cnt=1, log_valid=1, log_syn={1,6'd10}, log_tag = input tag.
- Double error: flip data bits 0 and 1 -> s=6, P=0, out_ue=1, out_data = raw flipped data, ue_cnt=1, log unchanged if already valid.
- Backpressure: out_ready=0 for 5 cycles while offering 3 words -> 2 accepted, in_ready=0, out_* stable. Release -> words emerge in order, one per cycle.
- Saturation/clear: COUNT_W=4, 20 CE words -> ce_cnt=15. stat_clr coincident with a CE handshake -> ce_cnt=1, log_valid=1.
- Reset mid-stream with 2 words in flight -> all outputs 0 and in_ready=1 after reset; no stale word emerges.
